mdc_commutator: RTL and testbench
=================================

# mdc_commutator

Radix-2 MDC data commutator for the 32-point FFT pipeline. It sits directly downstream of a butterfly stage and upstream of the next one, or of the final delay buffer. It reorders two parallel complex streams so that samples D apart form new butterfly pairs. Internally it uses two D-deep delay lines: one before the switch on the lower path, one after the switch on the upper path. Data advances only on accepted samples.

## Interface
- DEPTH, 16: delay D in samples; power of two, 1..16.
- WIDTH, 9: bit width of each real or imaginary component.

Ports:
- clk  in  1  master clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- di_en  in  1  input sample valid; one pair accepted per cycle while high.
- di0_re, di0_im  in  WIDTH  upper input stream.
- di1_re, di1_im  in  WIDTH  lower input stream.
- di_sync  in  1  frame-start marker, qualified by di_en. Present only with COMMUTATOR_SYNC_EN.
- do_en  out  1  output pair valid, registered.
- do0_re, do0_im  out  WIDTH  upper output stream, registered.
- do1_re, do1_im  out  WIDTH  lower output stream, registered.

## Operation
- Sample counter cnt, log2(D)+1 bits, counts accepted samples modulo 2D.
  - sel = cnt MSB (the bit of weight D).
  - For D=1, sel = cnt[0].
- Lower delay line LD: D stages fed from di1; its last stage is x1d.
- Switch, evaluated combinationally on accepted samples:
  - sel=0: s0=di0, s1=x1d.
  - sel=1: s0=x1d, s1=di0.
- Upper delay line UD: D stages fed from s0; its last stage is u.
- Output register, loaded only when di_en=1: do0 <= u, do1 <= s1.
- Pure data movement: no arithmetic, no rounding. All widths stay WIDTH; values pass bit-exact.
- Stall: with di_en=0, cnt, LD, UD and the output data registers hold, and do_en <= 0.
- Fill tracking:
  - filled is set when the D-th sample (index D-1) is accepted.
  - It stays set until rst.
  - do_en <= di_en & filled, evaluated before the current sample updates filled.
- Resulting ordering: input pairs (a_k, b_k) leave as (a_k, a_k+D) for one D-block, then (b_k, b_k+D) for the next.
- Stream tail: the last D output pairs of a stream need D further accepted samples. Upstream supplies the next frame or zero padding with di_en=1.
- Reset:
  - cnt=0, filled=0, all LD and UD stages 0.
  - do_en=0 and all do* outputs 0.
  - Reset mid-stream discards all in-flight data; the next accepted sample is index 0.
- Both delay lines use plain registers: no reset-dependent mux ordering and no RAM inference requirement.

## Timing
- Latency: the sample accepted at cycle t with index k≥D produces an output pair registered at t+1.
  - That pair contains data from input index k-D (do0) and from the current or earlier lower path (do1).
  - Equivalently, input to output is D accepted samples plus 1 clock.
- First do_en=1: the cycle after accepting sample index D.
- Throughput: 1 pair per cycle, with no bubbles beyond those on di_en.
- cnt wraps from 2D-1 to 0 without a gap; sel toggles every D accepted samples.
- rst and di_en high in the same cycle: rst wins and the sample is dropped.

## Configuration
- COMMUTATOR_SYNC_EN defined:
  - Adds the di_sync port.
  - When di_en=1 and di_sync=1, that sample is treated as cnt=0 (sel=0), and cnt becomes 1 afterwards.
  - Delay-line contents and filled are unaffected.
  - di_sync with di_en=0 is ignored.
- COMMUTATOR_SYNC_EN undefined:
  - No di_sync port.
  - cnt free-runs from reset; frames must be contiguous multiples of 2D samples.

## Test plan
- Reset check: with DEPTH=4, WIDTH=9, assert rst for 3 cycles with random inputs -> do_en=0 and all do*=0 throughout and on the first cycle after release.
- Reorder check: DEPTH=4, continuous di_en, di0=re 0..7 and di1=re 100..107 (imag = re+1).
  - First do_en on the cycle after index 4.
  - Pairs in order: (0,4), (1,5), (2,6), (3,7), (100,104), (101,105), ...
- Stall check: same stimulus with di_en low on every 3rd cycle -> identical output sequence; do_en=0 in the cycle after each gap; data holds.
- Boundary values: DEPTH=1 with inputs 255/-256 patterns (0x0FF/0x100).
  - Outputs (a0,a1), (b0,b1), (a2,a3), ...
  - Bit-exact; first do_en after index 1.
- Reset mid-stream: pulse rst at index 6 -> do_en=0 until index 4 of the new stream; no stale pre-reset values appear in any output.
- With COMMUTATOR_SYNC_EN: di_sync at index 2 -> cnt restarts, sel=0 for indices 2..5 and sel=1 for 6..9; the output pairing realigns to the new frame start.

Source files
------------

// File: rtl/mdc_commutator_if.sv
// Stream bundle between a butterfly stage and the MDC commutator; di_sync exists only with COMMUTATOR_SYNC_EN.
// master drives the input pair and receives the reordered pair; slave is the commutator side.
interface mdc_commutator_if #(
  parameter int WIDTH = 9
);
  logic             di_en;
  logic [WIDTH-1:0] di0_re, di0_im, di1_re, di1_im;
`ifdef COMMUTATOR_SYNC_EN
  logic             di_sync;
`endif
  logic             do_en;
  logic [WIDTH-1:0] do0_re, do0_im, do1_re, do1_im;

  modport master (
`ifdef COMMUTATOR_SYNC_EN
    output di_sync,
`endif
    output di_en, di0_re, di0_im, di1_re, di1_im,
    input  do_en, do0_re, do0_im, do1_re, do1_im
  );

  modport slave (
`ifdef COMMUTATOR_SYNC_EN
    input  di_sync,
`endif
    input  di_en, di0_re, di0_im, di1_re, di1_im,
    output do_en, do0_re, do0_im, do1_re, do1_im
  );
endinterface

// File: rtl/mdc_commutator.sv
// Radix-2 MDC commutator: pairs samples DEPTH apart (optional frame resync via COMMUTATOR_SYNC_EN).
// Latency DEPTH accepted samples + 1 clock; no backpressure, everything advances only on di_en.
module mdc_commutator #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input logic               clk,
  input logic               rst,
  mdc_commutator_if.slave   cm_io
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int DW = 2 * WIDTH;

  typedef logic [DW-1:0] cplx_t;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          filled_q, filled_d;
  logic          do_en_q;
  cplx_t         do0_q, do1_q;
  cplx_t         ld_q [DEPTH];
  cplx_t         ld_d [DEPTH];
  cplx_t         ud_q [DEPTH];
  cplx_t         ud_d [DEPTH];
  cplx_t         di0, di1, x1d, u, s0, s1;
  logic          sel;

`ifdef COMMUTATOR_SYNC_EN
  // Fill tracking counts samples since reset, independent of resync.
  logic [CW-1:0] fcnt_q, fcnt_d;
`endif

  always_comb begin
    di0 = {cm_io.di0_re, cm_io.di0_im};
    di1 = {cm_io.di1_re, cm_io.di1_im};
    x1d = ld_q[DEPTH-1];
    u   = ud_q[DEPTH-1];
`ifdef COMMUTATOR_SYNC_EN
    sel      = cm_io.di_sync ? 1'b0 : cnt_q[CW-1];
    cnt_d    = cm_io.di_sync ? CW'(1) : cnt_q + CW'(1);
    fcnt_d   = filled_q ? fcnt_q : fcnt_q + CW'(1);
    filled_d = filled_q | (fcnt_q == CW'(DEPTH - 1));
`else
    sel      = cnt_q[CW-1];
    cnt_d    = cnt_q + CW'(1);
    filled_d = filled_q | (cnt_q == CW'(DEPTH - 1));
`endif
    s0 = sel ? x1d : di0;
    s1 = sel ? di0 : x1d;
    ld_d[0] = di1;
    ud_d[0] = s0;
    for (int i = 1; i < DEPTH; i++) begin
      ld_d[i] = ld_q[i-1];
      ud_d[i] = ud_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      filled_q <= 1'b0;
      do_en_q  <= 1'b0;
      do0_q    <= '0;
      do1_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ld_q[i] <= '0;
        ud_q[i] <= '0;
      end
`ifdef COMMUTATOR_SYNC_EN
      fcnt_q <= '0;
`endif
    end else begin
      do_en_q <= cm_io.di_en & filled_q;
      if (cm_io.di_en) begin
        cnt_q    <= cnt_d;
        filled_q <= filled_d;
        do0_q    <= u;
        do1_q    <= s1;
        for (int i = 0; i < DEPTH; i++) begin
          ld_q[i] <= ld_d[i];
          ud_q[i] <= ud_d[i];
        end
`ifdef COMMUTATOR_SYNC_EN
        fcnt_q <= fcnt_d;
`endif
      end
    end
  end

  assign cm_io.do_en  = do_en_q;
  assign cm_io.do0_re = do0_q[DW-1:WIDTH];
  assign cm_io.do0_im = do0_q[WIDTH-1:0];
  assign cm_io.do1_re = do1_q[DW-1:WIDTH];
  assign cm_io.do1_im = do1_q[WIDTH-1:0];
endmodule

// File: tb/tb_mdc_commutator.sv
// Bench for mdc_commutator: DEPTH=4 and DEPTH=1 instances checked against a sample-history reorder model.
module tb_mdc_commutator;
  localparam int W = 9;

  logic clk = 1'b0;
  logic rst;
  logic started = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  int   base_a = 0;
  int   base_b = 100;

  always #5 clk = ~clk;

  mdc_commutator_if #(.WIDTH(W)) if4 ();
  mdc_commutator_if #(.WIDTH(W)) if1 ();

  mdc_commutator #(.DEPTH(4), .WIDTH(W)) dut4 (.clk(clk), .rst(rst), .cm_io(if4));
  mdc_commutator #(.DEPTH(1), .WIDTH(W)) dut1 (.clk(clk), .rst(rst), .cm_io(if1));

  // Model: full history of accepted pairs since reset; output for index k>=D is
  // (a[p], a[p+D]) when block p/D is even, else (b[p-D], b[p]), with p = k-D.
  logic [2*W-1:0] a_h [2][256];
  logic [2*W-1:0] b_h [2][256];
  int             kk  [2] = '{0, 0};
  logic           e_en[2] = '{1'b0, 1'b0};
  logic [2*W-1:0] e0  [2] = '{'0, '0};
  logic [2*W-1:0] e1  [2] = '{'0, '0};

  task automatic model_step(input int i, input int d, input logic r, input logic en,
                            input logic [2*W-1:0] a, input logic [2*W-1:0] b);
    int p;
    if (r) begin
      kk[i] = 0; e_en[i] = 1'b0; e0[i] = '0; e1[i] = '0;
    end else if (en) begin
      a_h[i][kk[i]] = a;
      b_h[i][kk[i]] = b;
      if (kk[i] >= d) begin
        p = kk[i] - d;
        if (((p / d) % 2) == 0) begin
          e0[i] = a_h[i][p];   e1[i] = a_h[i][p+d];
        end else begin
          e0[i] = b_h[i][p-d]; e1[i] = b_h[i][p];
        end
        e_en[i] = 1'b1;
      end else begin
        e0[i] = '0; e1[i] = '0; e_en[i] = 1'b0;
      end
      kk[i] = kk[i] + 1;
    end else begin
      e_en[i] = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    model_step(0, 4, rst, if4.di_en, {if4.di0_re, if4.di0_im}, {if4.di1_re, if4.di1_im});
    model_step(1, 1, rst, if1.di_en, {if1.di0_re, if1.di0_im}, {if1.di1_re, if1.di1_im});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("d4_en",  32'(if4.do_en), 32'(e_en[0]));
      chk("d4_do0", 32'({if4.do0_re, if4.do0_im}), 32'(e0[0]));
      chk("d4_do1", 32'({if4.do1_re, if4.do1_im}), 32'(e1[0]));
      chk("d1_en",  32'(if1.do_en), 32'(e_en[1]));
      chk("d1_do0", 32'({if1.do0_re, if1.do0_im}), 32'(e0[1]));
      chk("d1_do1", 32'({if1.do1_re, if1.do1_im}), 32'(e1[1]));
    end
  end

  task automatic drive(input logic en, input int k);
    logic [W-1:0] pa, pb;
    pa = k[0] ? 9'h100 : 9'h0FF;
    pb = k[0] ? 9'h0FF : 9'h100;
    if4.di_en  = en;
    if4.di0_re = W'(base_a + k);  if4.di0_im = W'(base_a + k + 1);
    if4.di1_re = W'(base_b + k);  if4.di1_im = W'(base_b + k + 1);
    if1.di_en  = en;
    if1.di0_re = pa;  if1.di0_im = pa ^ 9'h1FF;
    if1.di1_re = pb;  if1.di1_im = pb ^ 9'h1FF;
`ifdef COMMUTATOR_SYNC_EN
    if4.di_sync = 1'b0;
    if1.di_sync = 1'b0;
`endif
  endtask

  task automatic drive_rand(input logic en);
    drive(en, int'($urandom_range(0, 400)));
    if4.di0_re = W'($urandom); if4.di1_im = W'($urandom);
    if1.di0_im = W'($urandom); if1.di1_re = W'($urandom);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    int c;
    // Reset with random traffic
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_rand(1'($urandom_range(0, 1)));
      step();
      started = 1'b1;
      chk("rst_en4", 32'(if4.do_en), 32'd0);
      chk("rst_do0re4", 32'(if4.do0_re), 32'd0);
      chk("rst_do1re1", 32'(if1.do1_re), 32'd0);
    end
    rst = 1'b0;
    drive_rand(1'b0);
    step();
    chk("post_rst_en4", 32'(if4.do_en), 32'd0);
    chk("post_rst_do1im4", 32'(if4.do1_im), 32'd0);

    // Continuous reorder
    for (k = 0; k < 16; k++) begin
      drive(1'b1, k);
      step();
      if (k == 0) chk("d1_first_k0_en", 32'(if1.do_en), 32'd0);
      if (k == 1) begin
        chk("d1_k1_en", 32'(if1.do_en), 32'd1);
        chk("d1_k1_do0re", 32'(if1.do0_re), 32'h0FF);
        chk("d1_k1_do1re", 32'(if1.do1_re), 32'h100);
        chk("d1_k1_do1im", 32'(if1.do1_im), 32'h0FF);
      end
      if (k == 2) begin
        chk("d1_k2_do0re", 32'(if1.do0_re), 32'h100);
        chk("d1_k2_do1re", 32'(if1.do1_re), 32'h0FF);
      end
      if (k == 3) chk("d4_k3_en", 32'(if4.do_en), 32'd0);
      if (k == 4) begin
        chk("d4_k4_en", 32'(if4.do_en), 32'd1);
        chk("d4_k4_do0re", 32'(if4.do0_re), 32'd0);
        chk("d4_k4_do1re", 32'(if4.do1_re), 32'd4);
        chk("d4_k4_do1im", 32'(if4.do1_im), 32'd5);
      end
      if (k == 7) begin
        chk("d4_k7_do0re", 32'(if4.do0_re), 32'd3);
        chk("d4_k7_do1re", 32'(if4.do1_re), 32'd7);
      end
      if (k == 8) begin
        chk("d4_k8_do0re", 32'(if4.do0_re), 32'd100);
        chk("d4_k8_do1re", 32'(if4.do1_re), 32'd104);
      end
    end

    // Stalls every third cycle
    rst = 1'b1; drive(1'b0, 0); step(); rst = 1'b0;
    k = 0;
    c = 0;
    while (k < 16) begin
      if (c % 3 == 2) begin
        drive_rand(1'b0);
        step();
        chk("stall_gap_en4", 32'(if4.do_en), 32'd0);
        chk("stall_gap_en1", 32'(if1.do_en), 32'd0);
      end else begin
        drive(1'b1, k);
        step();
        if (k == 4) begin
          chk("stall_k4_do0re", 32'(if4.do0_re), 32'd0);
          chk("stall_k4_do1re", 32'(if4.do1_re), 32'd4);
        end
        if (k == 8) chk("stall_k8_do0re", 32'(if4.do0_re), 32'd100);
        k++;
      end
      c++;
    end

    // Reset mid-stream: rst wins over an accepted sample
    rst = 1'b1; drive(1'b0, 0); step(); rst = 1'b0;
    for (k = 0; k < 6; k++) begin
      drive(1'b1, k);
      step();
    end
    rst = 1'b1;
    drive(1'b1, 6);
    step();
    rst = 1'b0;
    base_a = 200;
    base_b = 300;
    for (k = 0; k < 10; k++) begin
      drive(1'b1, k);
      step();
      if (k == 3) begin
        chk("mid_k3_en4", 32'(if4.do_en), 32'd0);
        chk("mid_k3_do0re", 32'(if4.do0_re), 32'd0);
        chk("mid_k3_do1re", 32'(if4.do1_re), 32'd0);
      end
      if (k == 4) begin
        chk("mid_k4_en4", 32'(if4.do_en), 32'd1);
        chk("mid_k4_do0re", 32'(if4.do0_re), 32'd200);
        chk("mid_k4_do1re", 32'(if4.do1_re), 32'd204);
      end
    end
    drive(1'b0, 0);
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
